// File: rtl/uart_angle_deframer.sv
// Two-byte angle command deframer: header/parity/timeout/range checking between
// uart_rx and the modulator. Only validated angles update the angle register.
module uart_angle_deframer #(
  parameter logic [3:0]  HDR            = 4'hA,
  parameter int          TIMEOUT_CYCLES = 24000,
  parameter logic [11:0] ANGLE_MAX      = 12'd3599
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_done,
  input  logic        rx_parity_err,
  output logic [11:0] angle,
  output logic        angle_valid,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic [7:0]  err_count
);

  localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_PARITY  = 3'd1;
  localparam logic [2:0] E_HEADER  = 3'd2;
  localparam logic [2:0] E_TIMEOUT = 3'd3;
  localparam logic [2:0] E_RANGE   = 3'd4;

  typedef enum logic {IDLE, WAIT_LO} state_t;

  state_t        state_q, state_d;
  logic          rx_done_q, rx_done_d;
  logic          armed_q, armed_d;
  logic [3:0]    hi_nib_q, hi_nib_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   angle_q, angle_d;
  logic          angle_valid_q, angle_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [7:0]    err_count_q, err_count_d;

  logic          byte_ev;
  logic [11:0]   lo_word;
  logic [2:0]    err_sel;

  always_comb begin
    state_d       = state_q;
    rx_done_d     = rx_done;
    // rx_done already high at reset release must drop once before it can count
    armed_d       = armed_q | ~rx_done;
    hi_nib_d      = hi_nib_q;
    cnt_d         = cnt_q;
    angle_d       = angle_q;
    angle_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    err_count_d   = err_count_q;
    err_sel       = E_NONE;

    byte_ev = rx_done & ~rx_done_q & armed_q;
    lo_word = {hi_nib_q, rx_byte};

    case (state_q)
      IDLE: begin
        if (byte_ev) begin
          if (rx_parity_err) begin
            err_sel = E_PARITY;
          end else if (rx_byte[7:4] != HDR) begin
            err_sel = E_HEADER;
          end else begin
            hi_nib_d = rx_byte[3:0];
            cnt_d    = '0;
            state_d  = WAIT_LO;
          end
        end
      end
      WAIT_LO: begin
        // an event in the threshold cycle takes priority over the timeout
        if (byte_ev) begin
          state_d = IDLE;
          if (rx_parity_err) begin
            err_sel = E_PARITY;
          end else if (lo_word > ANGLE_MAX) begin
            err_sel = E_RANGE;
          end else begin
            angle_d       = lo_word;
            angle_valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_sel = E_TIMEOUT;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (err_sel != E_NONE) begin
      frame_err_d = 1'b1;
      err_code_d  = err_sel;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rx_done_q     <= 1'b0;
      armed_q       <= 1'b0;
      hi_nib_q      <= '0;
      cnt_q         <= '0;
      angle_q       <= '0;
      angle_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= E_NONE;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      rx_done_q     <= rx_done_d;
      armed_q       <= armed_d;
      hi_nib_q      <= hi_nib_d;
      cnt_q         <= cnt_d;
      angle_q       <= angle_d;
      angle_valid_q <= angle_valid_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      err_count_q   <= err_count_d;
    end
  end

  assign angle       = angle_q;
  assign angle_valid = angle_valid_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_uart_angle_deframer.sv
// Randomised and directed bench for uart_angle_deframer against a cycle-count
// based reference model.
module tb_uart_angle_deframer;
  localparam int T = 24000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_done = 1'b0;
  logic        rx_parity_err = 1'b0;
  logic [11:0] angle;
  logic        angle_valid;
  logic        frame_err;
  logic [2:0]  err_code;
  logic [7:0]  err_count;

  uart_angle_deframer dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_done(rx_done),
    .rx_parity_err(rx_parity_err), .angle(angle), .angle_valid(angle_valid),
    .frame_err(frame_err), .err_code(err_code), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks absolute edge numbers, a deadline for the low byte,
  // and whether rx_done has been seen low since the last rise.
  int   m_cyc = 0;
  bit   m_wait = 0;
  int   m_hi = 0;
  int   m_deadline = 0;
  bit   m_prev = 1;
  int   e_angle = 0, e_valid = 0, e_ferr = 0, e_code = 0, e_count = 0;

  initial begin : model_p
    bit ev;
    int err;
    int v;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_wait = 0; m_hi = 0; m_prev = 1;
        e_angle = 0; e_valid = 0; e_ferr = 0; e_code = 0; e_count = 0;
      end else begin
        m_cyc++;
        ev = rx_done && !m_prev;
        m_prev = rx_done;
        e_valid = 0; e_ferr = 0; err = 0;
        if (!m_wait) begin
          if (ev) begin
            if (rx_parity_err) err = 1;
            else if (rx_byte / 16 != 10) err = 2;
            else begin
              m_wait = 1; m_hi = rx_byte % 16; m_deadline = m_cyc + T;
            end
          end
        end else begin
          if (ev) begin
            v = m_hi * 256 + rx_byte;
            m_wait = 0;
            if (rx_parity_err) err = 1;
            else if (v > 3599) err = 4;
            else begin e_angle = v; e_valid = 1; end
          end else if (m_cyc == m_deadline) begin
            err = 3; m_wait = 0;
          end
        end
        if (err != 0) begin
          e_ferr = 1; e_code = err;
          if (e_count < 255) e_count++;
        end
      end
    end
  end

  int nvalid = 0, nferr = 0, edge_cnt = 0;

  initial begin : cmp_p
    forever begin
      @(negedge clk);
      chk("angle", int'(angle), e_angle);
      chk("angle_valid", int'(angle_valid), e_valid);
      chk("frame_err", int'(frame_err), e_ferr);
      chk("err_code", int'(err_code), e_code);
      chk("err_count", int'(err_count), e_count);
      if (angle_valid) nvalid++;
      if (frame_err) nferr++;
    end
  end

  initial begin : edge_p
    forever begin
      @(posedge clk);
      edge_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input logic p, input int hold);
    rx_byte = b;
    rx_parity_err = p;
    rx_done = 1'b1;
    repeat (hold) tick();
    rx_done = 1'b0;
    rx_parity_err = 1'($urandom_range(0, 1));
    rx_byte = 8'($urandom);
    tick();
  endtask

  initial begin : main_p
    int v0, f0, n0, k;
    logic [7:0] b;
    bit seen;

    // rx_done already high while reset is released
    rx_done = 1'b1;
    repeat (3) tick();
    chk("reset_angle", int'(angle), 0);
    chk("reset_count", int'(err_count), 0);
    reset = 1'b1;
    repeat (4) tick();
    rx_done = 1'b0;
    tick();
    chk("held_at_release_no_event", nferr + nvalid, 0);

    // nominal
    v0 = nvalid;
    send(8'hA1, 1'b0, 1);
    send(8'h2C, 1'b0, 1);
    chk("nominal_angle", int'(angle), 300);
    chk("nominal_pulses", nvalid - v0, 1);
    chk("nominal_count", int'(err_count), 0);

    // range, then parity on low byte
    send(8'hAE, 1'b0, 1);
    send(8'h10, 1'b0, 1);
    chk("range_code", int'(err_code), 4);
    chk("range_angle", int'(angle), 300);
    send(8'hA0, 1'b0, 1);
    send(8'h05, 1'b1, 1);
    chk("parity_code", int'(err_code), 1);
    chk("parity_angle", int'(angle), 300);

    // resync on bad header
    send(8'h51, 1'b0, 1);
    chk("resync_code", int'(err_code), 2);
    chk("resync_count", int'(err_count), 3);
    send(8'hA0, 1'b0, 1);
    send(8'h05, 1'b0, 1);
    chk("resync_angle", int'(angle), 5);

    // level handling
    v0 = nvalid;
    send(8'hA0, 1'b0, 5);
    send(8'h07, 1'b0, 5);
    chk("level_pulses", nvalid - v0, 1);
    chk("level_angle", int'(angle), 7);

    // timeout fires exactly T edges after the header edge
    rx_byte = 8'hA1; rx_parity_err = 1'b0; rx_done = 1'b1;
    tick();
    n0 = edge_cnt;
    rx_done = 1'b0;
    seen = 0;
    for (int i = 0; i < T + 100 && !seen; i++) begin
      tick();
      if (frame_err) seen = 1;
    end
    chk("timeout_seen", int'(seen), 1);
    chk("timeout_edge", edge_cnt - n0, T);
    chk("timeout_code", int'(err_code), 3);
    send(8'h2C, 1'b0, 1);
    chk("after_timeout_code", int'(err_code), 2);

    // low byte landing on the threshold edge still wins
    v0 = nvalid; f0 = nferr;
    send(8'hA3, 1'b0, 1);
    k = T - 2;
    repeat (k) tick();
    send(8'h21, 1'b0, 1);
    chk("boundary_angle", int'(angle), 12'h321);
    chk("boundary_pulses", nvalid - v0, 1);
    chk("boundary_no_err", nferr - f0, 0);

    // randomised byte stream
    for (int i = 0; i < 400; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1) b[7:4] = 4'hA;
      send(b, 1'($urandom_range(0, 9) == 0), int'($urandom_range(1, 4)));
      repeat ($urandom_range(0, 2)) tick();
    end

    // reset mid-frame
    send(8'hA1, 1'b0, 1);
    reset = 1'b0;
    tick();
    tick();
    chk("midreset_angle", int'(angle), 0);
    chk("midreset_code", int'(err_code), 0);
    chk("midreset_count", int'(err_count), 0);
    chk("midreset_pulses", int'(angle_valid) + int'(frame_err), 0);
    reset = 1'b1;
    tick();
    send(8'h2C, 1'b0, 1);
    chk("midreset_2c_code", int'(err_code), 2);
    chk("midreset_2c_count", int'(err_count), 1);

    // saturation
    f0 = nferr;
    for (int i = 0; i < 300; i++) send(8'h51, 1'b0, 1);
    chk("sat_pulses", nferr - f0, 300);
    chk("sat_count", int'(err_count), 255);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_angle_deframer.md
# uart_angle_deframer

Frame decoder between `uart_rx` and `modulator`. It takes the received byte stream (`data_received`, `rx_done`, `parity_error`) and assembles two-byte angle commands. Each command is checked for sync header, parity, inter-byte timeout and range. Only validated angles reach the 12-bit `angle` register that drives the modulator; malformed frames are dropped and counted.

## Interface
Parameters:
- `HDR`, 4'hA: required value of byte0[7:4] (sync nibble).
- `TIMEOUT_CYCLES`, 24000: max `clk` cycles from header-byte acceptance to low-byte arrival (1 ms at 24 MHz).
- `ANGLE_MAX`, 12'd3599: largest legal angle (0.1° units).

Ports:
- `clk`  in  1  system clock (`clk24` domain).
- `reset`  in  1  asynchronous, active-low reset.
- `rx_byte`  in  8  byte from `uart_rx.data_received`.
- `rx_done`  in  1  from `uart_rx`; may stay high for several cycles per byte.
- `rx_parity_err`  in  1  from `uart_rx.parity_error`; qualified by `rx_done`.
- `angle`  out  12  last validated angle; feeds `modulator.angle`.
- `angle_valid`  out  1  one-cycle pulse when `angle` is updated.
- `frame_err`  out  1  one-cycle pulse on any dropped frame or byte.
- `err_code`  out  3  code of the most recent error (sticky): 0 none, 1 parity, 2 header, 3 timeout, 4 range.
- `err_count`  out  8  dropped-frame count, saturates at 255.

## Operation
- Byte event: rising edge of `rx_done`, using a registered copy `rx_done_q`. Event when `rx_done & ~rx_done_q`.
  - A level held for any number of cycles is exactly one event.
  - `rx_byte` and `rx_parity_err` are sampled in the event cycle.
- Frame format: byte0 = {`HDR`, angle[11:8]}, byte1 = angle[7:0].
- FSM states: `IDLE`, `WAIT_LO`.
- `IDLE`, on event:
  - If parity error: error 1, stay `IDLE`.
  - Else if byte0[7:4] ≠ `HDR`: error 2, stay `IDLE` (resync; every byte is a header candidate).
  - Else: latch angle[11:8] into `hi_nib`, clear the timeout counter, go to `WAIT_LO`.
- `WAIT_LO`: the timeout counter increments every cycle without an event.
  - Event with parity error: error 1, go to `IDLE`.
  - Event with {`hi_nib`, `rx_byte`} > `ANGLE_MAX`: error 4, go to `IDLE`. `angle` is unchanged.
  - Event otherwise: `angle` <= {`hi_nib`, `rx_byte`}, pulse `angle_valid`, go to `IDLE`.
  - Byte1 is never header-checked.
  - If the counter reaches `TIMEOUT_CYCLES` with no event: error 3, go to `IDLE`.
- Error action (same cycle for all codes): pulse `frame_err`, load `err_code`, increment `err_count` unless it is 255.
- Counter width: `$clog2(TIMEOUT_CYCLES+1)` bits; no wrap is possible.
- Range compare is unsigned 12-bit.

## Timing
- Reset (asynchronous assert, `reset`=0): state `IDLE`, `rx_done_q`=0, `hi_nib`=0, counter=0, `angle`=0, `angle_valid`=0, `frame_err`=0, `err_code`=0, `err_count`=0. A frame in progress is discarded.
- Reset deassertion is synchronous to `clk` (external synchroniser).
- Latency: a low-byte event in cycle N gives `angle`/`angle_valid` (or `frame_err`/`err_code`) registered at the N+1 edge. `angle_valid` is high for exactly one cycle.
- `angle` never changes except with `angle_valid` (or reset).
- Timeout boundary: header accepted at edge N; the low-byte event is accepted through cycle N+`TIMEOUT_CYCLES`−1. Timeout fires at edge N+`TIMEOUT_CYCLES` if no event has occurred.
- Simultaneous event and timeout threshold in the same cycle: the event wins.
- Back-to-back frames are allowed with no idle gap. The minimum spacing is one cycle of `rx_done` low between bytes.
- `rx_done` high already at reset release: not an event until it falls and rises again.

## Test plan
- Nominal: bytes 0xA1, 0x2C → `angle`=0x12C (300), one-cycle `angle_valid`, `err_count`=0.
- Resync: 0x51, 0xA0, 0x05 → `frame_err`, `err_code`=2, `err_count`=1; then `angle`=5 with `angle_valid`.
- Timeout: 0xA1, then no byte for 24000 cycles → `err_code`=3 at exactly the 24000th edge. Following 0x2C → `err_code`=2.
- Range and parity: 0xAE, 0x10 (3600) → `err_code`=4, `angle` unchanged. 0xA0 + 0x05 with `parity_error`=1 on byte1 → `err_code`=1, `angle` unchanged.
- Level handling and saturation: `rx_done` held 5 cycles per byte on 0xA0, 0x07 → exactly one `angle_valid`, `angle`=7. 300 bad headers → `err_count`=255.
- Reset mid-frame: 0xA1, assert `reset` for 2 cycles, then 0x2C → all outputs at reset values; 0x2C is treated as a header → `err_code`=2.
